// File: rtl/writeback_if.sv
// Execute-to-writeback handshake bundle.
// Execute drives the instruction; writeback answers with ex_ready.
interface writeback_if #(
   parameter int XLEN = 32
);
   logic            ex_valid;
   logic            ex_ready;
   logic            ex_rf_wr;
   logic [4:0]      ex_rd;
   logic [1:0]      ex_wb_sel;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_alu_result;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_csr_rdata;

   modport master (
      output ex_valid, ex_rf_wr, ex_rd, ex_wb_sel, ex_funct3,
      output ex_alu_result, ex_pc, ex_csr_rdata,
      input  ex_ready
   );

   modport slave (
      input  ex_valid, ex_rf_wr, ex_rd, ex_wb_sel, ex_funct3,
      input  ex_alu_result, ex_pc, ex_csr_rdata,
      output ex_ready
   );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: holds one instruction, waits for load data when
// needed, selects and aligns the result and retires it to the RF.
module writeback_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   writeback_if.slave      ex,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rf_wr,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] wdata,
   output logic            fwd_valid,
   output logic [4:0]      fwd_rd,
   output logic [XLEN-1:0] fwd_data,
   output logic            load_pending,
   output logic [XLEN-1:0] instret
);

   typedef enum logic [1:0] {
      IDLE,
      COMMIT,
      WAIT_MEM
   } state_t;

   localparam logic [XLEN-1:0] ONE  = XLEN'(1);
   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   state_t          state;
   logic            wb_v;
   logic            wb_rf_wr;
   logic [4:0]      wb_rd;
   logic [1:0]      wb_sel;
   logic [2:0]      wb_funct3;
   logic [XLEN-1:0] wb_alu;
   logic [XLEN-1:0] wb_pc;
   logic [XLEN-1:0] wb_csr;

   logic            retire;
   logic            accept;
   logic [7:0]      ld_b;
   logic [15:0]     ld_h;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] result;

   assign load_pending = (state == WAIT_MEM);
   assign ex.ex_ready  = !load_pending || mem_rvalid;
   assign accept       = ex.ex_valid && ex.ex_ready;

   // mem_rvalid only matters while a load is outstanding
   assign retire = wb_v &&
      ((state == COMMIT) || (load_pending && mem_rvalid));

   always_comb begin
      ld_b = mem_rdata[7:0];
      unique case (wb_alu[1:0])
         2'd0: ld_b = mem_rdata[7:0];
         2'd1: ld_b = mem_rdata[15:8];
         2'd2: ld_b = mem_rdata[23:16];
         default: ld_b = mem_rdata[31:24];
      endcase
      ld_h = wb_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      unique case (wb_funct3)
         3'b000: ld_data = {{(XLEN-8){ld_b[7]}}, ld_b};
         3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_b};
         3'b001: ld_data = {{(XLEN-16){ld_h[15]}}, ld_h};
         3'b101: ld_data = {{(XLEN-16){1'b0}}, ld_h};
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      result = '0;
      unique case (1'b1)
         wb_sel == 2'b00: result = wb_alu;
         wb_sel == 2'b01: result = ld_data;
         wb_sel == 2'b10: result = wb_pc + FOUR;
         default: result = wb_csr;
      endcase
   end

   assign rf_wr     = retire && wb_rf_wr && (wb_rd != 5'd0);
   assign rd        = rf_wr ? wb_rd : 5'd0;
   assign wdata     = rf_wr ? result : '0;
   assign fwd_valid = rf_wr;
   assign fwd_rd    = rd;
   assign fwd_data  = wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wb_v      <= 1'b0;
         wb_rf_wr  <= 1'b0;
         wb_rd     <= 5'd0;
         wb_sel    <= 2'b00;
         wb_funct3 <= 3'b000;
         wb_alu    <= '0;
         wb_pc     <= '0;
         wb_csr    <= '0;
         instret   <= '0;
      end else begin
         if (retire) instret <= instret + ONE;
         if (accept) begin
            wb_v      <= 1'b1;
            wb_rf_wr  <= ex.ex_rf_wr;
            wb_rd     <= ex.ex_rd;
            wb_sel    <= ex.ex_wb_sel;
            wb_funct3 <= ex.ex_funct3;
            wb_alu    <= ex.ex_alu_result;
            wb_pc     <= ex.ex_pc;
            wb_csr    <= ex.ex_csr_rdata;
            state     <= (ex.ex_wb_sel == 2'b01) ? WAIT_MEM : COMMIT;
         end else if (retire) begin
            wb_v  <= 1'b0;
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus a randomized
// run against an instruction-level reference model.
module tb_writeback_stage;

  typedef struct {
    bit          wr;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] csr;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wr;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        load_pending;
  logic [31:0] instret;

  int total = 0;
  int bad = 0;
  int exp_ret = 0;

  writeback_if #(.XLEN(32)) bus ();

  writeback_stage #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .ex(bus.slave),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .rf_wr(rf_wr),
    .rd(rd),
    .wdata(wdata),
    .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd),
    .fwd_data(fwd_data),
    .load_pending(load_pending),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit v, input ins_t i);
    bus.ex_valid      = v;
    bus.ex_rf_wr      = i.wr;
    bus.ex_rd         = i.rd;
    bus.ex_wb_sel     = i.sel;
    bus.ex_funct3     = i.f3;
    bus.ex_alu_result = i.alu;
    bus.ex_pc         = i.pc;
    bus.ex_csr_rdata  = i.csr;
  endtask

  function automatic ins_t mk(input logic [4:0] r,
                              input logic [1:0] s,
                              input logic [2:0] f,
                              input logic [31:0] a,
                              input logic [31:0] p,
                              input logic [31:0] c);
    ins_t i;
    i.wr = 1'b1; i.rd = r; i.sel = s; i.f3 = f;
    i.alu = a; i.pc = p; i.csr = c;
    return i;
  endfunction

  // Architectural result of an instruction, straight from the ISA rules
  function automatic logic [31:0] ref_result(input ins_t i,
                                             input logic [31:0] md);
    longint unsigned v;
    int sh;
    case (i.sel)
      2'd0: return i.alu;
      2'd2: return 32'((longint'(i.pc) + 4) % 64'h1_0000_0000);
      2'd3: return i.csr;
      default: ;
    endcase
    case (i.f3)
      3'd0, 3'd4: begin
        sh = 8 * int'(i.alu[1:0]);
        v = (longint'(md) >> sh) % 256;
        if (i.f3 == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
        return 32'(v);
      end
      3'd1, 3'd5: begin
        sh = 16 * int'(i.alu[1]);
        v = (longint'(md) >> sh) % 65536;
        if (i.f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
        return 32'(v);
      end
      default: return md;
    endcase
  endfunction

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (rf_wr !== 1'b0 || rd !== 5'd0 || wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_wr got %b/%0d/%h want 0/0/0",
               rf_wr, rd, wdata);
    end
    total++;
    if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0
        || fwd_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_fwd got %b/%0d/%h want 0/0/0",
               fwd_valid, fwd_rd, fwd_data);
    end
    total++;
    if (bus.ex_ready !== 1'b1 || load_pending !== 1'b0
        || instret !== 32'd0) begin
      bad++;
      $display("FAIL reset_ctl got rdy=%b lp=%b ir=%0d want 1/0/0",
               bus.ex_ready, load_pending, instret);
    end
    rst = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_alu;
    ins_t i;
    i = mk(5'd5, 2'b00, 3'b000, 32'h1234, 32'h100, 32'h0);
    @(negedge clk);
    drive(1'b1, i);
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    #1;
    total++;
    if (rf_wr !== 1'b1 || rd !== 5'd5 || wdata !== 32'h1234) begin
      bad++;
      $display("FAIL alu_wr got %b/%0d/%h want 1/5/00001234",
               rf_wr, rd, wdata);
    end
    total++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5
        || fwd_data !== 32'h1234) begin
      bad++;
      $display("FAIL alu_fwd got %b/%0d/%h want 1/5/00001234",
               fwd_valid, fwd_rd, fwd_data);
    end
    @(posedge clk);
    exp_ret++;
    #1;
    total++;
    if (instret !== 32'(exp_ret) || rf_wr !== 1'b0) begin
      bad++;
      $display("FAIL alu_ret got ir=%0d wr=%b want %0d/0",
               instret, rf_wr, exp_ret);
    end
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3,
                           input logic [31:0] addr,
                           input logic [31:0] md,
                           input logic [31:0] want);
    ins_t i;
    i = mk(5'd7, 2'b01, f3, addr, 32'h200, 32'h0);
    @(negedge clk);
    drive(1'b1, i);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.ex_valid = 1'b0;
      mem_rdata = $urandom;
      #1;
      total++;
      if (bus.ex_ready !== 1'b0 || load_pending !== 1'b1
          || rf_wr !== 1'b0) begin
        bad++;
        $display("FAIL %s_wait%0d got rdy=%b lp=%b wr=%b want 0/1/0",
                 nm, k, bus.ex_ready, load_pending, rf_wr);
      end
    end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata = md;
    #1;
    total++;
    if (rf_wr !== 1'b1 || rd !== 5'd7 || wdata !== want
        || bus.ex_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_data got %b/%0d/%h rdy=%b want 1/7/%h rdy=1",
               nm, rf_wr, rd, wdata, bus.ex_ready, want);
    end
    @(posedge clk);
    exp_ret++;
    #1;
    mem_rvalid = 1'b0;
    total++;
    if (load_pending !== 1'b0 || instret !== 32'(exp_ret)) begin
      bad++;
      $display("FAIL %s_end got lp=%b ir=%0d want 0/%0d",
               nm, load_pending, instret, exp_ret);
    end
  endtask

  task automatic test_back_to_back;
    ins_t q[3];
    logic [31:0] w[3];
    q[0] = mk(5'd1, 2'b00, 3'b000, 32'hAAAA, 32'h0, 32'h0);
    q[1] = mk(5'd2, 2'b10, 3'b000, 32'h0, 32'hFFFF_FFFC, 32'h0);
    q[2] = mk(5'd3, 2'b11, 3'b000, 32'h0, 32'h0, 32'h5555);
    w[0] = 32'hAAAA; w[1] = 32'h0; w[2] = 32'h5555;
    @(negedge clk);
    drive(1'b1, q[0]);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) drive(1'b1, q[k+1]);
      else bus.ex_valid = 1'b0;
      #1;
      total++;
      if (rf_wr !== 1'b1 || rd !== q[k].rd || wdata !== w[k]
          || bus.ex_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d got %b/%0d/%h rdy=%b want 1/%0d/%h",
                 k, rf_wr, rd, wdata, bus.ex_ready, q[k].rd, w[k]);
      end
      @(posedge clk);
      exp_ret++;
    end
    #1;
    total++;
    if (rf_wr !== 1'b0 || instret !== 32'(exp_ret)) begin
      bad++;
      $display("FAIL b2b_end got wr=%b ir=%0d want 0/%0d",
               rf_wr, instret, exp_ret);
    end
  endtask

  task automatic test_rd0;
    ins_t i;
    i = mk(5'd0, 2'b00, 3'b000, 32'hDEAD, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, i);
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    #1;
    total++;
    if (rf_wr !== 1'b0 || fwd_valid !== 1'b0 || wdata !== 32'd0) begin
      bad++;
      $display("FAIL rd0_wr got %b/%b/%h want 0/0/0",
               rf_wr, fwd_valid, wdata);
    end
    @(posedge clk);
    exp_ret++;
    #1;
    total++;
    if (instret !== 32'(exp_ret)) begin
      bad++;
      $display("FAIL rd0_ret got %0d want %0d", instret, exp_ret);
    end
  endtask

  task automatic test_reset_wait;
    ins_t i;
    i = mk(5'd9, 2'b01, 3'b010, 32'h40, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, i);
    @(posedge clk);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (load_pending !== 1'b0 || bus.ex_ready !== 1'b1
        || instret !== 32'd0) begin
      bad++;
      $display("FAIL rstw_rst got lp=%b rdy=%b ir=%0d want 0/1/0",
               load_pending, bus.ex_ready, instret);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    #1;
    total++;
    if (rf_wr !== 1'b0 || load_pending !== 1'b0) begin
      bad++;
      $display("FAIL rstw_rv got wr=%b lp=%b want 0/0",
               rf_wr, load_pending);
    end
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    total++;
    if (instret !== 32'd0 || load_pending !== 1'b0
        || bus.ex_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstw_end got ir=%0d lp=%b rdy=%b want 0/0/1",
               instret, load_pending, bus.ex_ready);
    end
  endtask

  task automatic test_random;
    ins_t cur, nxt;
    bit have, v, rv, busy, ret, ew, acc;
    logic [31:0] md, ed;
    int errs;
    have = 0;
    errs = 0;
    cur = mk(5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_ret = 0;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom % 4) != 0;
      nxt.wr = $urandom % 2;
      nxt.rd = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
      nxt.sel = 2'($urandom);
      nxt.f3 = 3'($urandom);
      nxt.alu = $urandom;
      nxt.pc = ($urandom % 5 == 0) ? 32'hFFFF_FFFC : $urandom;
      nxt.csr = $urandom;
      rv = ($urandom % 3) == 0;
      md = $urandom;
      drive(v, nxt);
      mem_rvalid = rv;
      mem_rdata = md;
      #1;
      busy = have && cur.sel == 2'b01;
      ret = have && (!busy || rv);
      ew = ret && cur.wr && cur.rd != 5'd0;
      ed = ew ? ref_result(cur, md) : 32'd0;
      total++;
      if (bus.ex_ready !== (!busy || rv)
          || load_pending !== busy) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL rnd_ctl c=%0d got rdy=%b lp=%b want %b/%b",
                   c, bus.ex_ready, load_pending, !busy || rv, busy);
      end
      total++;
      if (rf_wr !== ew || rd !== (ew ? cur.rd : 5'd0)
          || wdata !== ed) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL rnd_wr c=%0d got %b/%0d/%h want %b/%0d/%h",
                   c, rf_wr, rd, wdata, ew,
                   ew ? cur.rd : 5'd0, ed);
      end
      total++;
      if (fwd_valid !== ew || fwd_data !== ed
          || instret !== 32'(exp_ret)) begin
        bad++;
        if (errs++ < 10)
          $display("FAIL rnd_fwd c=%0d got %b/%h ir=%0d want %b/%h/%0d",
                   c, fwd_valid, fwd_data, instret, ew, ed, exp_ret);
      end
      acc = v && (!busy || rv);
      if (ret) exp_ret++;
      if (acc) begin
        have = 1;
        cur = nxt;
      end else if (ret) begin
        have = 0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.ex_valid = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    ins_t z;
    z = mk(5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    drive(1'b0, z);
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    test_reset;
    test_alu;
    test_load("lb", 3'b000, 32'h1003, 32'h80FF_FFFF, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h1003, 32'h80FF_FFFF, 32'h0000_0080);
    test_load("lh", 3'b001, 32'h1002, 32'h7FFE_0000, 32'h0000_7FFE);
    test_load("lhu", 3'b101, 32'h1003, 32'h8001_3C5A, 32'h0000_8001);
    test_load("lw11", 3'b011, 32'h1001, 32'hCAFE_F00D, 32'hCAFE_F00D);
    test_back_to_back;
    test_rd0;
    test_reset_wait;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ex_valid  input  1  execute stage presents an instruction.
REQ-005 SHALL have port ex_ready  output  1  writeback stage accepts the instruction this cycle.
REQ-006 SHALL have port ex_rf_wr  input  1  instruction writes rd.
REQ-007 SHALL have port ex_rd  input  5  destination register index.
REQ-008 SHALL have port ex_wb_sel  input  2  result source: 00 ALU, 01 load, 10 pc+4, 11 CSR.
REQ-009 SHALL have port ex_funct3  input  3  load size and sign code.
REQ-010 SHALL have ports ex_alu_result, ex_pc and ex_csr_rdata  input  32  each, giving the ALU result or load address, the PC and the CSR read data.
REQ-011 SHALL have ports mem_rvalid  input  1 and mem_rdata  input  32, carrying the data-memory load response and its data.
REQ-012 SHALL have ports rf_wr  output  1, rd  output  5 and wdata  output  32, carrying the register-file write enable, index and data.
REQ-013 SHALL have ports fwd_valid  output  1, fwd_rd  output  5 and fwd_data  output  32, which mirror the write for bypass to execute.
REQ-014 SHALL have port load_pending  output  1  high while waiting on a load response.
REQ-015 SHALL have port instret  output  32  count of retired instructions.

Function
REQ-016 SHALL accept an instruction at a posedge where ex_valid and ex_ready are both 1, capturing all ex_* fields into a WB register with valid bit wb_v.
REQ-017 SHALL implement the states IDLE, COMMIT and WAIT_MEM.
REQ-018 SHALL move to COMMIT on acceptance when ex_wb_sel != 01, and to WAIT_MEM when ex_wb_sel == 01.
REQ-019 SHALL retire the captured instruction in COMMIT during the single cycle after acceptance.
REQ-020 SHALL, from COMMIT, return to IDLE at the next edge, or go to COMMIT or WAIT_MEM if a new instruction is accepted at that edge.
REQ-021 SHALL stay in WAIT_MEM until mem_rvalid=1, retire the load in that same cycle, then follow the REQ-020 transitions.
REQ-022 SHALL hold ex_ready=1 in IDLE and COMMIT, and in WAIT_MEM only while mem_rvalid=1, giving back-to-back throughput of 1 instruction per cycle.
REQ-023 SHALL drive load_pending=1 exactly while in WAIT_MEM.
REQ-024 SHALL ignore mem_rvalid in IDLE and COMMIT, with no effect on state or outputs.
REQ-025 SHALL drive rf_wr combinationally as (retiring cycle) AND wb_rf_wr AND (wb_rd != 0).
REQ-026 SHALL assert rf_wr for exactly one cycle per retired writing instruction.
REQ-027 SHALL drive rd = wb_rd and wdata = the selected result when rf_wr=1, and rd=0 and wdata=0 otherwise.
REQ-028 SHALL select the result by wb_sel: 00 gives wb_alu_result; 10 gives wb_pc+4 (modulo 2^32, 0xFFFFFFFC gives 0x00000000); 11 gives wb_csr_rdata; 01 gives the aligned load data.
REQ-029 SHALL form load data from mem_rdata using byte offset wb_alu_result[1:0].
REQ-030 SHALL extract for LB (000) and LBU (100) the byte at offset*8, sign-extended and zero-extended respectively.
REQ-031 SHALL extract for LH (001) and LHU (101) the halfword at wb_alu_result[1]*16, sign-extended and zero-extended respectively, ignoring bit 0.
REQ-032 SHALL use the full mem_rdata for LW (010), ignoring the offset, and SHALL treat funct3 codes 011, 110 and 111 as LW.
REQ-033 SHALL drive fwd_valid, fwd_rd and fwd_data identical to rf_wr, rd and wdata in the same cycle.
REQ-034 SHALL increment instret by 1 per retired instruction, whether or not it writes and including rd=0, wrapping 0xFFFFFFFF to 0.

Reset
REQ-035 SHALL, while rst=1, immediately force state=IDLE, wb_v=0, instret=0, rf_wr=0, rd=0, wdata=0, fwd_*=0, load_pending=0 and ex_ready=1.
REQ-036 SHALL, on reset during WAIT_MEM, abandon the load: no register write, no instret increment, and a later mem_rvalid is ignored per REQ-024.
REQ-037 SHALL, after rst deasserts, accept an instruction at the first posedge.

Verification
REQ-038 SHALL cover: ALU op accepted with rd=5, alu_result=0x1234 -> next cycle rf_wr=1, rd=5, wdata=0x1234, instret=1.
REQ-039 SHALL cover: LB at address offset 3 with mem_rvalid after 3 wait cycles and mem_rdata=0x80FFFFFF -> ex_ready=0 and load_pending=1 for 3 cycles, then wdata=0xFFFFFF80; the same case as LBU gives 0x00000080.
REQ-040 SHALL cover: LH at offset 2 with mem_rdata=0x7FFE0000 -> wdata=0x00007FFE; LHU with mem_rdata=0x8001xxxx -> wdata=0x00008001.
REQ-041 SHALL cover: back-to-back ALU, JAL (pc=0xFFFFFFFC, sel 10) and CSR ops -> three consecutive rf_wr pulses, the JAL pulse with wdata=0, and ex_ready held at 1.
REQ-042 SHALL cover: write to rd=0 -> rf_wr=0 and fwd_valid=0, while instret still increments.
REQ-043 SHALL cover: rst asserted mid WAIT_MEM, then mem_rvalid=1 -> no write, instret=0 and state IDLE.
